// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch into a 2-entry in-order buffer.
// The PC walks forward by one word per fetch, stalls when the buffer is full,
// and is redirected (with a full buffer flush) on a branch/jump request.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [7:0]  out_pc
);

    localparam logic [7:0] RESET_PC_ALIGNED = RESET_PC & 8'hFC;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr_q [BUF_DEPTH];
    logic [31:0] instr_d [BUF_DEPTH];
    logic [7:0]  epc_q   [BUF_DEPTH];
    logic [7:0]  epc_d   [BUF_DEPTH];

    logic       pop;
    logic       fetch;
    logic [1:0] wr_idx;

    assign imem_addr = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = out_valid ? instr_q[0] : '0;
    assign out_pc    = out_valid ? epc_q[0]   : '0;

    assign pop   = out_valid & out_ready;
    assign fetch = (state_q == RUN) & ~redirect_valid & ((count_q < 2'd2) | pop);

    // Entry 0 is always the head; a pop shifts entry 1 down, so a push lands
    // at the slot just past the surviving entries (count minus pop).
    assign wr_idx = count_q - {1'b0, pop};

    // Next-state computation for PC, buffer occupancy and buffer contents
    always_comb begin
        state_d = fetch_en ? RUN : IDLE;
        pc_d    = pc_q;
        count_d = count_q;
        instr_d = instr_q;
        epc_d   = epc_q;
        if (redirect_valid) begin
            pc_d    = redirect_target & 8'hFC;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                instr_d[0] = instr_q[1];
                epc_d[0]   = epc_q[1];
            end
            if (fetch) begin
                instr_d[wr_idx[0]] = imem_rdata;
                epc_d[wr_idx[0]]   = pc_q;
                pc_d               = pc_q + 8'd4;
            end
            count_d = count_q + {1'b0, fetch} - {1'b0, pop};
        end
    end

    // FSM and datapath registers, asynchronously cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_ALIGNED;
            count_q <= 2'd0;
            instr_q <= '{default: '0};
            epc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
            epc_q   <= epc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;

    logic [31:0] mem [64];

    int passed;
    int total;

    typedef struct {
        logic [31:0] instr;
        int          pc;
    } ent_t;

    ent_t q[$];
    int   mpc;
    bit   running;

    fetch_unit #(
        .RESET_PC (8'h00),
        .BUF_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign imem_rdata = mem[imem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk("out_pc", {24'd0, out_pc}, (q.size() != 0) ? 32'(q[0].pc) : 32'd0);
        chk("out_instr", out_instr, (q.size() != 0) ? q[0].instr : 32'd0);
        chk("imem_addr", {24'd0, imem_addr}, 32'(mpc));
    endtask

    task automatic model_reset();
        q.delete();
        mpc     = 0;
        running = 0;
    endtask

    // One clock: advance the model from the current inputs, then compare
    task automatic step();
        bit pop;
        bit fetch;
        pop   = (q.size() != 0) && out_ready;
        fetch = running && !redirect_valid && ((q.size() < 2) || pop);
        if (redirect_valid) begin
            q.delete();
            mpc = int'(redirect_target) - (int'(redirect_target) % 4);
        end else begin
            if (pop) void'(q.pop_front());
            if (fetch) begin
                q.push_back('{mem[mpc / 4], mpc});
                mpc = (mpc + 4) % 256;
            end
        end
        running = fetch_en;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset applied in the post-edge phase, released one edge later
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        rst_n           = 1'b0;
        fetch_en        = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Sequential fetch from reset with consumer always ready
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("first_edge_empty", {31'd0, out_valid}, 32'd0);
        step();
        chk("first_pc", {24'd0, out_pc}, 32'h00);
        chk("first_instr", out_instr, mem[0]);
        step();
        chk("seq_pc04", {24'd0, out_pc}, 32'h04);
        step();
        chk("seq_pc08", {24'd0, out_pc}, 32'h08);
        step();
        chk("seq_pc0C", {24'd0, out_pc}, 32'h0C);
        chk("seq_instr0C", out_instr, mem[3]);

        // Backpressure: fill to two entries and stall
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        repeat (5) step();
        chk("stall_addr", {24'd0, imem_addr}, 32'h08);
        chk("stall_head", {24'd0, out_pc}, 32'h00);
        out_ready = 1'b1;
        step();
        chk("drain_04", {24'd0, out_pc}, 32'h04);
        step();
        chk("drain_08", {24'd0, out_pc}, 32'h08);
        step();
        chk("drain_0C", {24'd0, out_pc}, 32'h0C);

        // Redirect with a full buffer, unaligned target
        out_ready = 1'b0;
        repeat (2) step();
        redirect_valid  = 1'b1;
        redirect_target = 8'h31;
        step();
        redirect_valid = 1'b0;
        chk("redir_flush", {31'd0, out_valid}, 32'd0);
        chk("redir_addr", {24'd0, imem_addr}, 32'h30);
        step();
        chk("redir_head", {24'd0, out_pc}, 32'h30);

        // PC wrap-around
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 8'hFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_FC", {24'd0, out_pc}, 32'hFC);
        step();
        chk("wrap_00", {24'd0, out_pc}, 32'h00);
        step();
        chk("wrap_04", {24'd0, out_pc}, 32'h04);

        // Drop fetch_en with one entry, drain, then resume
        fetch_en = 1'b0;
        repeat (4) step();
        chk("idle_empty", {31'd0, out_valid}, 32'd0);
        fetch_en = 1'b1;
        repeat (3) step();

        // Asynchronous reset between edges with a full buffer
        out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_addr", {24'd0, imem_addr}, 32'h00);
        check_all();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        fetch_en = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("post_reset_idle", {31'd0, out_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            fetch_en        = ($urandom_range(0, 7) != 0);
            out_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 15) == 0);
            redirect_target = 8'($urandom);
            step();
        end
        redirect_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning byte address loaded into the PC on reset (bits [1:0] ignored, treated as 0).
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries (fixed at 2; other values not supported).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetch_en  input  1  level; 1 = fetching permitted.
REQ-006 SHALL have port imem_addr  output  8  byte address to instruction memory (combinational read, word index = addr[7:2]).
REQ-007 SHALL have port imem_rdata  input  32  instruction word returned by instruction memory in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-009 SHALL have port redirect_target  input  8  redirect byte address.
REQ-010 SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port out_ready  input  1  decode stage accepts head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction word.
REQ-013 SHALL have port out_pc  output  8  byte address of head instruction.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, RUN.
REQ-015 IDLE -> RUN on rising edge with fetch_en=1; RUN -> IDLE on rising edge with fetch_en=0; redirect does not change state.
REQ-016 SHALL drive imem_addr = {pc[7:2], 2'b00} continuously from the PC register.
REQ-017 pop SHALL = out_valid & out_ready.
REQ-018 fetch SHALL = (state==RUN) & ~redirect_valid & (count<2 | pop).
REQ-019 On fetch, SHALL push {imem_rdata, pc} into buffer tail and set pc <= pc + 4 at the same edge.
REQ-020 PC arithmetic SHALL be 8-bit modulo: 8'hFC + 4 -> 8'h00, no flag.
REQ-021 Buffer SHALL be a 2-entry FIFO, in-order; out_valid = (count!=0); out_instr/out_pc SHALL reflect head, held stable while out_valid & ~out_ready.
REQ-022 Simultaneous push and pop SHALL keep count unchanged, including at count=2.
REQ-023 Latency: instruction at pc fetched in cycle N SHALL appear at buffer head (if buffer was empty) with out_valid=1 in cycle N+1.
REQ-024 redirect_valid=1 SHALL at next edge: clear buffer (count<=0), set pc <= {redirect_target[7:2], 2'b00}, suppress any fetch that cycle; priority over fetch and pop.
REQ-025 A pop in the same cycle as redirect_valid SHALL count as a completed transfer for the consumer; buffer still fully cleared.
REQ-026 In IDLE, no push SHALL occur; pops SHALL continue draining the buffer; pc SHALL hold.
REQ-027 When count=2 and no pop, pc and buffer SHALL hold (stall); imem_addr stays constant.
REQ-028 out_instr/out_pc SHALL be 0 when out_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force: state=IDLE, pc={RESET_PC[7:2],2'b00}, count=0, out_valid=0, out_instr=0, out_pc=0, imem_addr={RESET_PC[7:2],2'b00}.
REQ-030 Reset asserted mid-operation SHALL discard buffer contents and any pending redirect; first fetch after release requires fetch_en=1 sampled in IDLE (one edge to enter RUN, fetch from next cycle).

Verification
REQ-031 Reset release, fetch_en=1, out_ready=1, memory of sequential instructions -> first out_valid with out_pc=8'h00 two cycles after release, then out_pc 04, 08, 0C on consecutive cycles, out_instr matching memory words.
REQ-032 out_ready=0 for 5 cycles while running -> count reaches 2, pc stops at 8'h08, head stays out_pc=00; out_ready=1 -> 00, 04, 08 delivered in order with no gap or duplicate.
REQ-033 redirect_valid pulse with redirect_target=8'h31 while buffer holds 2 entries -> next cycle out_valid=0, imem_addr=8'h30; following cycle out_pc=8'h30.
REQ-034 pc=8'hFC in RUN with out_ready=1 -> out_pc sequence FC, 00, 04 (wrap-around).
REQ-035 rst_n driven low between clock edges with count=2 -> out_valid=0 and imem_addr=RESET_PC immediately, before next edge; fetch_en=0 -> stays IDLE, no out_valid.
REQ-036 fetch_en dropped with count=1, out_ready=1 -> remaining entry delivered, then out_valid=0, pc frozen; fetch_en re-asserted -> fetch resumes at frozen pc.
